dmem_access_ctrl: RTL and testbench

Memory-stage access controller sitting directly upstream of `DMemory_IO` (128-word data RAM plus memory-mapped 7-segment display and switch ports). It accepts one load or store request at a time from the processor over a valid/ready handshake. It sequences the `dm_*` strobes with stable address and data, captures read data, and returns a single response per request. Optional address checking rejects accesses outside the memory map before they reach `DMemory_IO`.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_addr_decode.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 118 +++++++++++
 tb/tb_dmem_access_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
// Optional address checking is enabled with DMEM_ADDR_CHECK_EN.
package dmem_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int ADDR_W_DEF    = 16;
    localparam int RAM_WORDS_DEF = 128;

    localparam logic [15:0] IO_DISP_ADDR = 16'hFFFA;
    localparam logic [15:0] IO_SW_ADDR   = 16'hFFF0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_addr_decode.sv
// Combinational memory-map decode for the access controller.
// Used only when DMEM_ADDR_CHECK_EN is defined.
module dmem_addr_decode
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int RAM_WORDS = RAM_WORDS_DEF
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    output logic              is_ram,
    output logic              is_disp,
    output logic              is_sw,
    output logic              illegal
);

    assign is_ram  = (addr < ADDR_W'(RAM_WORDS));
    assign is_disp = (addr == ADDR_W'(IO_DISP_ADDR));
    assign is_sw   = (addr == ADDR_W'(IO_SW_ADDR));

    // Display is write-only, switches are read-only.
    assign illegal = !(is_ram || is_disp || is_sw)
                   || (is_sw && write)
                   || (is_disp && !write);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding load/store sequencer in front of DMemory_IO.
// Define DMEM_ADDR_CHECK_EN to reject accesses outside the memory map.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              dm_write,
    output logic              dm_read,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              busy,
    output dmem_state_e       state_dbg
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. Payloads
    // are held stable while valid is high and not yet taken.

    dmem_state_e state;
    logic        wr_q;
    logic        reject;

`ifdef DMEM_ADDR_CHECK_EN
    logic dec_is_ram;
    logic dec_is_disp;
    logic dec_is_sw;

    dmem_addr_decode #(
        .ADDR_W    (ADDR_W),
        .RAM_WORDS (RAM_WORDS_DEF)
    ) u_decode (
        .addr    (req_addr),
        .write   (req_write),
        .is_ram  (dec_is_ram),
        .is_disp (dec_is_disp),
        .is_sw   (dec_is_sw),
        .illegal (reject)
    );
`else
    assign reject = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            dm_write  <= 1'b0;
            dm_read   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        dm_addr   <= req_addr;
                        dm_wdata  <= req_wdata;
                        wr_q      <= req_write;
                        rsp_rdata <= '0;
                        rsp_err   <= reject;
                        if (reject) begin
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            dm_write <= req_write;
                            dm_read  <= !req_write;
                            state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    dm_write <= 1'b0;
                    if (wr_q) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Read strobe spans ISSUE and CAPTURE; data is taken at the end of CAPTURE.
                    dm_read   <= 1'b0;
                    rsp_rdata <= dm_rdata;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: a DMemory_IO-like environment, a reference
// memory map model with an expected-response queue, directed and random traffic.
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_write;
    logic        dm_read;
    logic [15:0] dm_rdata;
    logic        busy;
    dmem_state_e state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    // Environment memory driven only by the DUT strobes
    logic [15:0] env_mem [128];
    logic [15:0] env_disp;
    logic [1:0]  sw;

    // Reference model state, updated from the request stream
    logic [15:0] ref_mem [128];
    logic [15:0] ref_disp;
    logic [16:0] exp_q [$];

    dmem_access_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_write  (dm_write),
        .dm_read   (dm_read),
        .dm_rdata  (dm_rdata),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    always @(posedge clock) begin
        if (dm_write) begin
            if (dm_addr < 16'd128) env_mem[dm_addr[6:0]] <= dm_wdata;
            else if (dm_addr == 16'hFFFA) env_disp <= dm_wdata;
        end
    end

    always_comb begin
        dm_rdata = 16'h0;
        if (dm_addr < 16'd128) dm_rdata = env_mem[dm_addr[6:0]];
        else if (dm_addr == 16'hFFF0) dm_rdata = {14'h0, sw};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_illegal(input logic wr, input logic [15:0] addr);
`ifdef DMEM_ADDR_CHECK_EN
        logic mapped;
        mapped = (addr < 16'd128) || (addr == 16'hFFFA) || (addr == 16'hFFF0);
        return !mapped || (wr && addr == 16'hFFF0) || (!wr && addr == 16'hFFFA);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] addr);
        if (addr < 16'd128) return ref_mem[addr[6:0]];
        if (addr == 16'hFFF0) return {14'h0, sw};
        return 16'h0;
    endfunction

    task automatic ref_write(input logic [15:0] addr, input logic [15:0] wd);
        if (addr < 16'd128) ref_mem[addr[6:0]] = wd;
        else if (addr == 16'hFFFA) ref_disp = wd;
    endtask

    // Driver: one transaction starting at a negedge, ending at a negedge in IDLE.
    // hold = cycles rsp_ready stays low after rsp_valid; pend presents the next request during the hold.
    logic        nxt_wr;
    logic [15:0] nxt_addr;
    logic [15:0] nxt_wd;

    task automatic do_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                          input int hold, input logic pend);
        logic        e_err;
        logic [15:0] e_data;
        logic [16:0] e_rsp;
        int          e_lat;
        int          guard;
        int          lat;
        int          wcnt;
        int          rcnt;

        e_err  = ref_illegal(wr, addr);
        e_data = (!e_err && !wr) ? ref_read(addr) : 16'h0;
        exp_q.push_back({e_err, e_data});
        if (!e_err && wr) ref_write(addr, wd);
        e_lat = e_err ? 1 : (wr ? 2 : 3);

        rsp_ready = (hold == 0);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check_eq("accept_wait", 32'(guard < 20), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        req_write = 1'($urandom);

        lat = 1;
        wcnt = 0;
        rcnt = 0;
        forever begin
            if (dm_write) begin
                wcnt++;
                check_eq("wr_addr", 32'(dm_addr), 32'(addr));
                check_eq("wr_data", 32'(dm_wdata), 32'(wd));
            end
            if (dm_read) begin
                rcnt++;
                check_eq("rd_addr", 32'(dm_addr), 32'(addr));
            end
            if (dm_read && dm_write) check_eq("strobe_excl", 32'd1, 32'd0);
            if (rsp_valid || lat >= 10) break;
            @(negedge clock);
            lat++;
        end
        e_rsp = exp_q.pop_front();
        check_eq("rsp_latency", 32'(lat), 32'(e_lat));
        check_eq("wr_cycles", 32'(wcnt), 32'((!e_err && wr) ? 1 : 0));
        check_eq("rd_cycles", 32'(rcnt), 32'((!e_err && !wr) ? 2 : 0));
        check_eq("rsp_err", 32'(rsp_err), 32'(e_rsp[16]));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(e_rsp[15:0]));
        check_eq("req_ready_resp", 32'(req_ready), 32'd0);

        for (int h = 0; h < hold; h++) begin
            if (pend) begin
                req_valid = 1'b1;
                req_write = nxt_wr;
                req_addr  = nxt_addr;
                req_wdata = nxt_wd;
            end
            @(negedge clock);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_rdata", 32'(rsp_rdata), 32'(e_rsp[15:0]));
            check_eq("hold_err", 32'(rsp_err), 32'(e_rsp[16]));
            check_eq("hold_ready", 32'(req_ready), 32'd0);
            check_eq("hold_strobes", 32'({dm_write, dm_read}), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        check_eq("rsp_done", 32'(rsp_valid), 32'd0);
        check_eq("idle_ready", 32'(req_ready), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("disp", 32'(env_disp), 32'(ref_disp));
    endtask

    logic [15:0] a;
    logic        w;
    int          hold;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        rsp_ready = 1'b1;
        sw        = 2'b00;
        env_disp  = 16'h0;
        ref_disp  = 16'h0;
        for (int i = 0; i < 128; i++) begin
            env_mem[i] = 16'($urandom);
            ref_mem[i] = env_mem[i];
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check_eq("rst_dm_addr", 32'(dm_addr), 32'd0);
        check_eq("rst_dm_wdata", 32'(dm_wdata), 32'd0);
        check_eq("rst_strobes", 32'({dm_write, dm_read}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // Store then load back, display write, switch reads
        do_txn(1'b1, 16'd6, 16'd5, 0, 1'b0);
        do_txn(1'b0, 16'd6, 16'h0, 0, 1'b0);
        do_txn(1'b1, 16'hFFFA, 16'd14, 0, 1'b0);
        sw = 2'b10;
        do_txn(1'b0, 16'hFFF0, 16'h0, 0, 1'b0);
        sw = 2'b01;
        do_txn(1'b0, 16'hFFF0, 16'h0, 0, 1'b0);

        // Response back-pressure with a second request waiting
        nxt_wr   = 1'b0;
        nxt_addr = 16'd6;
        nxt_wd   = 16'h0;
        do_txn(1'b1, 16'd6, 16'hBEEF, 5, 1'b1);
        do_txn(nxt_wr, nxt_addr, nxt_wd, 0, 1'b0);

        // Map boundaries: out of range store, load from the display, store to switches
        do_txn(1'b1, 16'd200, 16'h1234, 0, 1'b0);
        do_txn(1'b0, 16'hFFFA, 16'h0, 0, 1'b0);
        do_txn(1'b1, 16'hFFF0, 16'h5555, 0, 1'b0);
        do_txn(1'b0, 16'd127, 16'h0, 0, 1'b0);
        do_txn(1'b0, 16'd128, 16'h0, 2, 1'b0);

        // Reset during the CAPTURE cycle of a load
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'd3;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check_eq("cap_read", 32'(dm_read), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("mid_rst_read", 32'(dm_read), 32'd0);
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        check_eq("post_rst_valid", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 16'd3, 16'h0, 0, 1'b0);

        // Random traffic
        for (int t = 0; t < 120; t++) begin
            w = 1'($urandom);
            case ($urandom_range(0, 9))
                0:       a = 16'hFFFA;
                1:       a = 16'hFFF0;
                2:       a = 16'($urandom_range(128, 1000));
                3, 4:    a = 16'($urandom_range(0, 127));
                default: a = 16'($urandom_range(0, 15));
            endcase
            sw   = 2'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_txn(w, a, 16'($urandom), hold, 1'b0);
        end

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
